// File: rtl/lsu_pkg.sv
// Shared widths, RV32 load/store funct3 encodings and the access legality check.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // High when the request must complete with an error and never touch memory.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic e;
    e = 1'b0;
    if (we) e = (f3 > F3_W);
    else    e = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if ((f3[1:0] == 2'b01) && off[0]) e = 1'b1;
    if ((f3 == F3_W) && (off != 2'b00)) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and SB/SH read-modify-write merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = word[{off, 3'b000} +: 8];
    half_v     = word[{off[1], 4'b0000} +: 16];
    load_data  = word;
    store_word = word;
    case (funct3[1:0])
      2'b00: begin
        load_data = {{24{byte_v[7] & ~funct3[2]}}, byte_v};
        store_word[{off, 3'b000} +: 8] = wdata[7:0];
      end
      2'b01: begin
        load_data = {{16{half_v[15] & ~funct3[2]}}, half_v};
        store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit driving a word-wide, 1-cycle-latency data memory; one op outstanding.
// Latency: SW and errors 2 cycles, loads and SB/SH 3 cycles from accept to resp_valid.
module lsu
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERR    = 3'd1,
    S_LD_RD  = 3'd2,
    S_LD_DAT = 3'd3,
    S_ST_WR  = 3'd4,
    S_RMW_RD = 3'd5,
    S_RMW_WR = 3'd6
  } state_t;

  state_t          state, state_n;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;
  logic            accept;

  assign accept    = (state == S_IDLE) && req_valid;
  assign dmem_addr = {addr_q[XLEN-1:2], 2'b00};

  // Shared by LD_DAT (extract) and RMW_WR (merge); dmem_rdata is the word read the cycle before.
  lsu_align u_align (
    .off        (addr_q[1:0]),
    .funct3     (funct3_q),
    .word       (dmem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    dmem_we    = 1'b0;
    dmem_wdata = wdata_q;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (access_err(req_we, req_funct3, req_addr[1:0])) state_n = S_ERR;
          else if (!req_we)                                   state_n = S_LD_RD;
          else if (req_funct3 == F3_W)                        state_n = S_ST_WR;
          else                                                state_n = S_RMW_RD;
        end
      end
      S_LD_RD:  state_n = S_LD_DAT;
      S_RMW_RD: state_n = S_RMW_WR;
      S_ST_WR: begin
        dmem_we = 1'b1;
        state_n = S_IDLE;
      end
      S_RMW_WR: begin
        dmem_we    = 1'b1;
        dmem_wdata = store_word;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

  // Response registers: rdata/err hold between responses, valid pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end
        S_LD_DAT, S_ST_WR, S_RMW_WR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= we_q ? '0 : load_data;
        end
        default: ;
      endcase
    end
  end

endmodule
